// File: rtl/rca_multiword_add_seq.sv
// Multi-word adder: one shared 32-bit ripple-carry adder stepped over NUM_WORDS words, LSW first.
// Latency NUM_WORDS+1 cycles from accepted start to done; start is dropped unless ready.

module RCA_32_bit (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        c_i,
    output logic [31:0] s_o,
    output logic        c_o
);
    logic [32:0] c;

    assign c[0] = c_i;

    for (genvar i = 0; i < 32; i++) begin : g_fa
        assign s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
        assign c[i + 1] = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end

    assign c_o = c[32];
endmodule

module rca_multiword_add_seq #(
    parameter  int NUM_WORDS = 4,
    localparam int W         = 32 * NUM_WORDS,
    localparam int IDXW      = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [W-1:0]    a,
    input  logic [W-1:0]    b,
    input  logic            c_in,
    output logic            ready,
    output logic            busy,
    output logic            done,
    output logic [IDXW-1:0] word_idx,
    output logic [W-1:0]    s,
    output logic            c_out
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_WORDS - 1);

    state_t          state_q;
    logic [W-1:0]    a_q, b_q, acc_q, acc_d, s_q;
    logic            carry_q, c_out_q;
    logic [IDXW-1:0] idx_q;
    logic            ready_q, busy_q, done_q;

    logic [IDXW+4:0] word_off;
    logic [31:0]     rca_a, rca_b, rca_s;
    logic            rca_c;

    assign word_off = {idx_q, 5'd0};
    assign rca_a    = a_q[word_off +: 32];
    assign rca_b    = b_q[word_off +: 32];

    RCA_32_bit u_rca (
        .a_i (rca_a),
        .b_i (rca_b),
        .c_i (carry_q),
        .s_o (rca_s),
        .c_o (rca_c)
    );

    // Accumulator including the word being added this cycle; on the last word
    // this is the complete sum, so s can be loaded in one step.
    always_comb begin
        acc_d                 = acc_q;
        acc_d[word_off +: 32] = rca_s;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            s_q     <= '0;
            c_out_q <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= c_in;
                        acc_q   <= '0;
                        idx_q   <= '0;
                        state_q <= RUN;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    acc_q   <= acc_d;
                    carry_q <= rca_c;
                    if (idx_q == LAST_IDX) begin
                        s_q     <= acc_d;
                        c_out_q <= rca_c;
                        idx_q   <= '0;
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    idx_q   <= '0;
                end
            endcase
        end
    end

    assign ready    = ready_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign word_idx = idx_q;
    assign s        = s_q;
    assign c_out    = c_out_q;
endmodule

// File: tb/tb_rca_multiword_add_seq.sv
// Directed bench for rca_multiword_add_seq (NUM_WORDS=4): scoreboard queue of expected
// {c_out,s} pushed on accepted start, popped when done pulses.
module tb_rca_multiword_add_seq;
    localparam int NW = 4;
    localparam int W  = 32 * NW;

    logic         clk = 1'b0;
    logic         rst, start, c_in;
    logic [W-1:0] a, b;
    logic         ready, busy, done, c_out;
    logic [1:0]   word_idx;
    logic [W-1:0] s;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;
    int cyc = 0;
    logic [W:0] exp_q[$];

    rca_multiword_add_seq #(.NUM_WORDS(NW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .c_in     (c_in),
        .ready    (ready),
        .busy     (busy),
        .done     (done),
        .word_idx (word_idx),
        .s        (s),
        .c_out    (c_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [W:0] obs, input logic [W:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    endfunction

    // Scoreboard side: every done must match the oldest pending expectation.
    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            chk("done_not_busy", busy, 0);
            chk("done_has_expect", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) chk("result", {c_out, s}, exp_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    task automatic wait_ready();
        for (int w = 0; w < 20 && !ready; w++) @(negedge clk);
        chk("ready_before_op", ready, 1);
    endtask

    // Drive one op, check the RUN sequence and done latency; optionally pulse a
    // competing start at word_idx=2 which must be ignored.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                          input bit inject);
        int cnt0;
        wait_ready();
        cnt0 = done_cnt;
        a = ta; b = tb_; c_in = tc; start = 1'b1;
        exp_q.push_back(model(ta, tb_, tc));
        @(negedge clk);
        start = 1'b0;
        a = {4{$urandom}}; b = {4{$urandom}}; c_in = ~tc;
        for (int k = 0; k < NW; k++) begin
            chk("run_busy", busy, 1);
            chk("run_ready", ready, 0);
            chk("run_done", done, 0);
            chk("run_word_idx", word_idx, k);
            if (inject) begin
                start = (k == 2);
                a = 100; b = 100;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("done_latency", done, 1);
        chk("done_ready", ready, 0);
        @(negedge clk);
        chk("after_done_ready", ready, 1);
        chk("after_done_pulse", done, 0);
        @(negedge clk);
        @(negedge clk);
        chk("single_done", done_cnt - cnt0, 1);
    endtask

    initial begin
        int cnt0, accepts, last;
        logic [W-1:0] ra, rb;
        logic         rc;
        rst = 1'b1; start = 1'b1; a = '1; b = '1; c_in = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ready", ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_word_idx", word_idx, 0);
        chk("rst_s", s, 0);
        chk("rst_c_out", c_out, 0);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);

        // T1 basic, T2 inter-word carry
        run_op(128'd1, 128'd1, 1'b0, 0);
        chk("t1_s", s, 128'd2);
        run_op(128'hFFFFFFFF, 128'd1, 1'b0, 0);
        chk("t2_s", s, 128'h1_00000000);
        chk("t2_c_out", c_out, 0);

        // T3 full wrap and decimal case
        run_op({W{1'b1}}, 128'd0, 1'b1, 0);
        chk("t3_wrap", {c_out, s}, {1'b1, 128'd0});
        run_op(128'd123456784, 128'd98765432, 1'b1, 0);
        chk("t3_dec", s, 128'd222222217);

        // T4 start while busy is dropped
        run_op(128'd5, 128'd7, 1'b0, 1);
        chk("t4_s", s, 128'd12);
        chk("t4_no_second", busy, 0);

        // T5 reset mid-op
        wait_ready();
        cnt0 = done_cnt;
        a = 128'h1234; b = 128'h5678; c_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("t5_idx2", word_idx, 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_ready", ready, 1);
        chk("t5_busy", busy, 0);
        chk("t5_s", s, 0);
        chk("t5_c_out", c_out, 0);
        chk("t5_word_idx", word_idx, 0);
        repeat (6) @(negedge clk);
        chk("t5_no_done", done_cnt - cnt0, 0);
        run_op(128'd4294967290, 128'd67, 1'b1, 0);
        chk("t5_s_after", {c_out, s}, {1'b0, 128'd4294967358});

        // T6 back-to-back with start held high
        cnt0 = done_cnt;
        accepts = 0;
        last = 0;
        start = 1'b1;
        for (int t = 0; t < 60 && accepts < 3; t++) begin
            if (ready) begin
                ra = {$urandom, $urandom, $urandom, $urandom};
                rb = {$urandom, $urandom, $urandom, $urandom};
                rc = 1'($urandom);
                a = ra; b = rb; c_in = rc;
                exp_q.push_back(model(ra, rb, rc));
                if (accepts > 0) chk("t6_interval", cyc - last, NW + 2);
                last = cyc;
                accepts++;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("t6_accepts", accepts, 3);
        repeat (10) @(negedge clk);
        chk("t6_dones", done_cnt - cnt0, 3);
        chk("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
